// File: rtl/mvm_engine_p.sv
`default_nettype none
// ============================================================================
//  Module   : mvm_engine_p
//  Purpose  : Parametrised matrix-vector multiplier C = A x B built from a
//             skewed chain of per-row MAC stages with start/busy/done control.
//  Revision : 1.0  initial release
// ============================================================================
module mvm_engine_p #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int SIGNED = 0
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       a_wr_en,
    input  logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] a_wr_row,
    input  logic [DATA_W-1:0]                          a_wr_data,
    input  logic                                       b_wr_en,
    input  logic [DATA_W-1:0]                          b_wr_data,
    input  logic                                       start,
    input  logic                                       a_keep,
    output logic                                       a_ready,
    output logic                                       b_ready,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       err,
    output logic [ACC_W-1:0]                           c_out [ROWS]
);

    localparam int c_ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int c_CNT_W     = $clog2(COLS + 1);
    localparam int c_COL_W     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int c_CYC_W     = $clog2(COLS + ROWS);
    localparam int c_EXEC_LAST = COLS + ROWS - 2;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CLR  = 2'd1;
    localparam logic [1:0] c_ST_EXEC = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CYC_W-1:0] r_cyc;
    logic               r_keep;
    logic               r_err;

    logic [DATA_W-1:0]  r_a     [ROWS][COLS];
    logic [c_CNT_W-1:0] r_a_cnt [ROWS];
    logic [DATA_W-1:0]  r_b     [COLS];
    logic [c_CNT_W-1:0] r_b_cnt;

    logic               w_a_we  [ROWS];
    logic               w_a_full_all;
    logic               w_b_full;
    logic               w_idle;
    logic               w_row_hit;
    logic               w_row_full;
    logic               w_a_ok;
    logic               w_b_ok;
    logic               w_start_ok;
    logic               w_start_bad;
    logic               w_err_set;

    // Per-stage inputs of the MAC chain and their forwarding registers
    logic               w_clr   [ROWS];
    logic               w_en    [ROWS];
    logic [DATA_W-1:0]  w_b     [ROWS];
    logic [c_COL_W-1:0] w_col   [ROWS];
    logic               r_clr_q [ROWS];
    logic               r_en_q  [ROWS];
    logic [DATA_W-1:0]  r_b_q   [ROWS];
    logic [c_COL_W-1:0] r_col_q [ROWS];
    logic [ACC_W-1:0]   w_ext   [ROWS];

    // ------------------------------------------------------------------
    // Fill-state and write legality
    // ------------------------------------------------------------------
    always_comb begin
        w_a_full_all = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            if (r_a_cnt[r] != c_CNT_W'(COLS)) w_a_full_all = 1'b0;
        end
    end

    assign w_b_full = (r_b_cnt == c_CNT_W'(COLS));
    assign w_idle   = (r_state == c_ST_IDLE);

    always_comb begin
        w_row_hit  = 1'b0;
        w_row_full = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (a_wr_row == c_ROW_W'(r)) begin
                w_row_hit  = 1'b1;
                w_row_full = (r_a_cnt[r] == c_CNT_W'(COLS));
            end
        end
        w_a_ok = a_wr_en && w_idle && w_row_hit && !w_row_full;
        for (int r = 0; r < ROWS; r++) begin
            w_a_we[r] = w_a_ok && (a_wr_row == c_ROW_W'(r));
        end
        w_b_ok      = b_wr_en && w_idle && !w_b_full;
        w_start_ok  = w_idle && start && w_a_full_all && w_b_full;
        w_start_bad = w_idle && start && !(w_a_full_all && w_b_full);
        w_err_set   = (a_wr_en && !w_a_ok) || (b_wr_en && !w_b_ok) || w_start_bad;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_start_ok) w_state_nxt = c_ST_CLR;
            c_ST_CLR:  w_state_nxt = c_ST_EXEC;
            c_ST_EXEC: if (r_cyc == c_CYC_W'(c_EXEC_LAST)) w_state_nxt = c_ST_DONE;
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state != c_ST_IDLE);
        done    = (r_state == c_ST_DONE);
        a_ready = w_a_full_all;
        b_ready = w_b_full;
        err     = r_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc  <= '0;
            r_keep <= 1'b0;
        end else begin
            r_cyc <= (r_state == c_ST_EXEC) ? r_cyc + 1'b1 : '0;
            if (w_start_ok) r_keep <= a_keep;
        end
    end

    // ------------------------------------------------------------------
    // Fill counters and sticky error; DONE recycles the buffers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) r_a_cnt[r] <= '0;
            r_b_cnt <= '0;
            r_err   <= 1'b0;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                if (r_state == c_ST_DONE && !r_keep) r_a_cnt[r] <= '0;
                else if (w_a_we[r])                  r_a_cnt[r] <= r_a_cnt[r] + 1'b1;
            end
            if (r_state == c_ST_DONE) r_b_cnt <= '0;
            else if (w_b_ok)          r_b_cnt <= r_b_cnt + 1'b1;
            if (w_err_set)       r_err <= 1'b1;
            else if (w_start_ok) r_err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (w_a_we[r] && r_a_cnt[r] == c_CNT_W'(c)) r_a[r][c] <= a_wr_data;
            end
        end
        for (int c = 0; c < COLS; c++) begin
            if (w_b_ok && r_b_cnt == c_CNT_W'(c)) r_b[c] <= b_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Skewed chain: stage 0 is fed by the FSM, stage r by stage r-1 a cycle later
    // ------------------------------------------------------------------
    always_comb begin
        w_clr[0] = (r_state == c_ST_CLR);
        w_en[0]  = (r_state == c_ST_EXEC) && (r_cyc < c_CYC_W'(COLS));
        w_col[0] = r_cyc[c_COL_W-1:0];
        w_b[0]   = r_b[r_cyc[c_COL_W-1:0]];
        for (int r = 1; r < ROWS; r++) begin
            w_clr[r] = r_clr_q[r-1];
            w_en[r]  = r_en_q[r-1];
            w_col[r] = r_col_q[r-1];
            w_b[r]   = r_b_q[r-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                r_clr_q[r] <= 1'b0;
                r_en_q[r]  <= 1'b0;
                r_col_q[r] <= '0;
                r_b_q[r]   <= '0;
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                r_clr_q[r] <= w_clr[r];
                r_en_q[r]  <= w_en[r];
                r_col_q[r] <= w_col[r];
                r_b_q[r]   <= w_b[r];
            end
        end
    end

    for (genvar gr = 0; gr < ROWS; gr++) begin : g_mac
        logic [DATA_W-1:0] w_a_el;
        logic [ACC_W-1:0]  r_acc;

        assign w_a_el = r_a[gr][w_col[gr]];

        if (SIGNED != 0) begin : g_signed
            logic signed [2*DATA_W-1:0] w_prod;
            assign w_prod = $signed({{DATA_W{w_a_el[DATA_W-1]}}, w_a_el})
                          * $signed({{DATA_W{w_b[gr][DATA_W-1]}}, w_b[gr]});
            assign w_ext[gr] = ACC_W'(w_prod);
        end else begin : g_unsigned
            logic [2*DATA_W-1:0] w_prod;
            assign w_prod = {{DATA_W{1'b0}}, w_a_el} * {{DATA_W{1'b0}}, w_b[gr]};
            assign w_ext[gr] = ACC_W'(w_prod);
        end

        // Accumulator doubles as the result register; wraps modulo 2^ACC_W
        always_ff @(posedge clk) begin
            if (rst)             r_acc <= '0;
            else if (w_clr[gr])  r_acc <= '0;
            else if (w_en[gr])   r_acc <= r_acc + w_ext[gr];
        end

        assign c_out[gr] = r_acc;
    end

endmodule
`default_nettype wire
